// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer. Each destination has its own 2-entry FIFO,
// so one stalled consumer never blocks the other three. DEMUX_1_4_STATS_EN adds per-channel delivered-word counters.
module demux_1_4_stream #(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [4*W-1:0]   out_data,
    output logic [31:0]      stat_count
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 8;

    logic [W-1:0] mem_q [NCH][DEPTH];
    logic [W-1:0] mem_d [NCH][DEPTH];
    logic [NCH-1:0] wr_ptr_q, wr_ptr_d;
    logic [NCH-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]     occ_q [NCH];
    logic [1:0]     occ_d [NCH];

    logic           push;
    logic [NCH-1:0] pop;

    // Handshake and head-of-FIFO outputs come only from registered state.
    always_comb begin
        in_ready  = (occ_q[in_sel] != 2'd2);
        push      = in_valid & in_ready;
        out_valid = '0;
        out_data  = '0;
        pop       = '0;
        for (int i = 0; i < NCH; i++) begin
            out_valid[i]        = (occ_q[i] != 2'd0);
            out_data[i*W +: W]  = mem_q[i][rd_ptr_q[i]];
            pop[i]              = out_valid[i] & out_ready[i];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        for (int i = 0; i < NCH; i++) begin
            if (push && (in_sel == 2'(i))) begin
                mem_d[i][wr_ptr_q[i]] = in_data;
                wr_ptr_d[i]           = ~wr_ptr_q[i];
            end
            if (pop[i]) begin
                rd_ptr_d[i] = ~rd_ptr_q[i];
            end
            case ({push && (in_sel == 2'(i)), pop[i]})
                2'b10:   occ_d[i] = occ_q[i] + 2'd1;
                2'b01:   occ_d[i] = occ_q[i] - 2'd1;
                default: occ_d[i] = occ_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                occ_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

`ifdef DEMUX_1_4_STATS_EN
    logic [CW-1:0] cnt_q [NCH];
    logic [CW-1:0] cnt_d [NCH];

    // Saturating delivered-word counters, cleared only by reset.
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pop[i] && (cnt_q[i] != {CW{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            stat_count[i*CW +: CW] = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign stat_count = '0;
`endif

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1-to-4 stream demultiplexer: routes each word accepted on a single valid/ready input to one of four valid/ready outputs chosen by a per-word 2-bit select. It is the distribution counterpart of the 4:1 mux in the combinational-logic set. It gives every destination its own 2-entry buffer, so a stalled output never blocks traffic to the others. It sits between a single producer and four independent consumers.

## Interface
- W, 4, data width in bits (≥1)
- clk  input  1  rising-edge clock; sole clock domain
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_data  input  W  input word
- in_sel  input  2  destination channel index 0..3; meaningful only while in_valid=1
- out_valid  output  4  bit i: channel i head word present
- out_ready  input  4  bit i: consumer i accepts
- out_data  output  4*W  channel i head word on bits [i*W +: W]
- stat_count  output  32  channel i delivered-word count on bits [i*8 +: 8]

## Operation
- Per channel i: 2-entry FIFO (storage, read/write pointer, occupancy 0..2).
- in_ready = (occupancy[in_sel] != 2). This is combinational from in_sel and registered occupancy only. It must not depend on out_ready, so there is no combinational in→out path.
- Input transfer: in_valid & in_ready at a rising edge. in_data is written into FIFO[in_sel]. No other channel changes.
- Output transfer on channel i: out_valid[i] & out_ready[i] at a rising edge. The head entry is popped.
- out_valid[i] = (occupancy[i] != 0). out_data slice i = head entry of FIFO i. The slice is held stable while out_valid[i]=1 and not popped.
- Order within a channel is strictly preserved. There is no ordering relation between channels.
- Push and pop on the same channel in the same cycle: occupancy is unchanged, and the pushed word lands behind the remaining entries.
- Pops on any subset of channels and one push all proceed in the same cycle.
- Occupancy 2 with a simultaneous pop on that channel: in_ready for that channel stays 0. There is no same-cycle pass-through.
- Pointers are 1 bit and wrap 1→0.
- out_data for an empty channel is don't-care. Reset clears it to 0.
- Reset values:
  - out_valid = 4'b0000
  - out_data = 0
  - stat_count = 0
  - all occupancies and pointers = 0
  - in_ready = 1 after reset, since every channel is empty
- rst mid-operation discards all buffered words. Inputs presented in the reset cycle are ignored.

## Timing
- Latency: a word accepted at edge k appears as out_valid[in_sel]=1 in the cycle following edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle into any channel whose consumer holds out_ready=1 continuously (steady occupancy 1).
- A stalled channel absorbs 2 words, then deasserts in_ready only while in_sel points to it.

## Configuration
- Macro: DEMUX_1_4_STATS_EN.
- Defined:
  - stat_count slice i increments by 1 on each output transfer of channel i.
  - It saturates at 8'hFF and is cleared only by rst.
- Undefined: stat_count is constant 0 and no counter flops are generated.
- Datapath and handshake behaviour are identical in both builds.

## Test plan
- Reset then idle: rst=1 for 2 cycles → out_valid=0000, stat_count=0, in_ready=1.
- Routing and latency: push 4'hA,4'hB,4'hC,4'hD with in_sel=0,1,2,3 and out_ready=1111 → each appears on its channel exactly 1 cycle after acceptance; no other channel asserts valid.
- Backpressure isolation:
  - Setup: out_ready[2]=0; push 3 words to channel 2, then words to channel 0.
  - Required: in_ready=0 only while in_sel=2 after 2 words are buffered; channel 0 traffic continues.
  - Raising out_ready[2] delivers the 2 buffered words in order.
- Full throughput: 16 back-to-back words to channel 1 with out_ready[1]=1 → in_ready stays 1 and data emerges in order at 1 word/cycle.
- Reset mid-stream:
  - Setup: both entries of channel 3 full; assert rst for 1 cycle.
  - Required: out_valid[3]=0 next cycle; the old words never appear.
- Stats (DEMUX_1_4_STATS_EN defined): deliver 300 words on channel 0 → stat_count[7:0]=8'hFF, other slices 0. Same run without the macro → stat_count=0 throughout.
